// File: rtl/data_bus_bridge.sv
// data_bus_bridge: steers CPU data accesses to the data RAM or a small MMIO
// register window, returning read data with one-cycle synchronous-SRAM timing.
module data_bus_bridge #(
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
    parameter int          SW_W      = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            data_sram_en,
    input  logic            data_sram_wen,
    input  logic [31:0]     data_sram_addr,
    input  logic [3:0]      data_sram_wmask,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    output logic            ram_en,
    output logic            ram_wen,
    output logic [31:0]     ram_addr,
    output logic [3:0]      ram_wmask,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata,
    input  logic [SW_W-1:0] switch,
    output logic [SW_W-1:0] led,
    output logic            timer_irq
);
    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_CMP     = 16'h000C;
    localparam logic [15:0] OFF_IRQ     = 16'h0010;
    localparam logic [15:0] OFF_SCRATCH = 16'h0014;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (mask[b])
                res[8*b +: 8] = new_val[8*b +: 8];
        return res;
    endfunction

    logic            hit_mmio;
    logic [15:0]     off;
    logic            mmio_wr;
    logic            mmio_rd;
    logic            any_mask;
    logic [SW_W-1:0] led_q;
    logic [SW_W-1:0] led_merged;
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [31:0]     timer_q;
    logic [31:0]     timer_next;
    logic [31:0]     cmp_q;
    logic [31:0]     scratch_q;
    logic            irq_q;
    logic            irq_clr;
    logic            irq_next;
    logic [31:0]     rd_val;
    logic [31:0]     rdata_q;
    logic            sel_mmio_q;

    always_comb begin
        hit_mmio = data_sram_en && (data_sram_addr[31:16] == MMIO_BASE[31:16]);
        off      = data_sram_addr[15:0];
        mmio_wr  = hit_mmio && data_sram_wen;
        mmio_rd  = hit_mmio && !data_sram_wen;
        any_mask = |data_sram_wmask;
    end

    assign ram_en    = data_sram_en & ~hit_mmio;
    assign ram_wen   = ram_en & data_sram_wen;
    assign ram_wmask = ram_en ? data_sram_wmask : 4'b0000;
    assign ram_addr  = data_sram_addr;
    assign ram_wdata = data_sram_wdata;

    // Register read mux sees pre-update values of the current cycle
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_LED:     rd_val = 32'(led_q);
            OFF_SWITCH:  rd_val = 32'(sw_s2);
            OFF_TIMER:   rd_val = timer_q;
            OFF_CMP:     rd_val = cmp_q;
            OFF_IRQ:     rd_val = {31'd0, irq_q};
            OFF_SCRATCH: rd_val = scratch_q;
            default:     rd_val = '0;
        endcase
    end

    // A CPU timer write replaces the increment; the compare uses the old count
    always_comb begin
        led_merged = SW_W'(merge_bytes(32'(led_q), data_sram_wdata, data_sram_wmask));
        timer_next = timer_q + 32'd1;
        if (mmio_wr && (off == OFF_TIMER) && any_mask)
            timer_next = merge_bytes(timer_q, data_sram_wdata, data_sram_wmask);
        irq_clr  = mmio_wr && (off == OFF_IRQ) && data_sram_wmask[0] && data_sram_wdata[0];
        irq_next = (timer_q == cmp_q) || (irq_q && !irq_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q      <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            timer_q    <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            scratch_q  <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            sel_mmio_q <= 1'b0;
        end else begin
            sw_s1   <= switch;
            sw_s2   <= sw_s1;
            timer_q <= timer_next;
            irq_q   <= irq_next;
            if (mmio_wr && (off == OFF_LED))
                led_q <= led_merged;
            if (mmio_wr && (off == OFF_CMP))
                cmp_q <= merge_bytes(cmp_q, data_sram_wdata, data_sram_wmask);
            if (mmio_wr && (off == OFF_SCRATCH))
                scratch_q <= merge_bytes(scratch_q, data_sram_wdata, data_sram_wmask);
            // Read-return stage: steering flag holds across idle cycles
            if (data_sram_en)
                sel_mmio_q <= mmio_rd;
            if (mmio_rd)
                rdata_q <= rd_val;
        end
    end

    assign data_sram_rdata = sel_mmio_q ? rdata_q : ram_rdata;
    assign led             = led_q;
    assign timer_irq       = irq_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a register-level model.
module tb_data_bus_bridge;
    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic        data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wmask;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        ram_en;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] switch;
    logic [15:0] led;
    logic        timer_irq;

    data_bus_bridge #(.MMIO_BASE(32'hBFAF_0000), .SW_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wmask(data_sram_wmask),
        .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .switch(switch), .led(led), .timer_irq(timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Model state: register file contents and the outstanding read return
    logic [15:0] m_led;
    logic [31:0] m_timer, m_cmp, m_scratch;
    logic        m_irq;
    logic [15:0] m_sw1, m_sw2;
    logic        m_pend_mmio;
    logic [31:0] m_pend_val;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] o);
        case (o)
            16'h0000: return {16'h0000, m_led};
            16'h0004: return {16'h0000, m_sw2};
            16'h0008: return m_timer;
            16'h000C: return m_cmp;
            16'h0010: return {31'd0, m_irq};
            16'h0014: return m_scratch;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = 16'h0; m_timer = 32'd0; m_cmp = 32'hFFFF_FFFF; m_scratch = 32'd0;
        m_irq = 1'b0; m_sw1 = 16'h0; m_sw2 = 16'h0;
        m_pend_mmio = 1'b0; m_pend_val = 32'd0;
    endtask

    task automatic model_clock();
        logic        hit, match, clr;
        logic [15:0] o;
        logic [31:0] rd, t_new, tmp;
        if (!resetn) begin
            model_reset();
            return;
        end
        hit   = data_sram_en && (data_sram_addr[31:16] == 16'hBFAF);
        o     = data_sram_addr[15:0];
        rd    = model_read(o);
        match = (m_timer == m_cmp);
        t_new = m_timer + 32'd1;
        clr   = 1'b0;
        if (hit && data_sram_wen) begin
            case (o)
                16'h0000: begin
                    tmp = tb_merge({16'h0, m_led}, data_sram_wdata, data_sram_wmask);
                    m_led = tmp[15:0];
                end
                16'h0008: if (data_sram_wmask != 4'b0000)
                              t_new = tb_merge(m_timer, data_sram_wdata, data_sram_wmask);
                16'h000C: m_cmp = tb_merge(m_cmp, data_sram_wdata, data_sram_wmask);
                16'h0010: clr = data_sram_wmask[0] && data_sram_wdata[0];
                16'h0014: m_scratch = tb_merge(m_scratch, data_sram_wdata, data_sram_wmask);
                default: ;
            endcase
        end
        m_timer = t_new;
        if (match)    m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        m_sw2 = m_sw1;
        m_sw1 = switch;
        if (data_sram_en) begin
            m_pend_mmio = hit && !data_sram_wen;
            if (hit && !data_sram_wen)
                m_pend_val = rd;
        end
    endtask

    task automatic compare_now();
        logic hit, e_ram_en;
        hit      = data_sram_en && (data_sram_addr[31:16] == 16'hBFAF);
        e_ram_en = data_sram_en && !hit;
        check32("ram_en", {31'd0, ram_en}, {31'd0, e_ram_en});
        check32("ram_wen", {31'd0, ram_wen}, {31'd0, e_ram_en && data_sram_wen});
        check32("ram_wmask", {28'd0, ram_wmask}, {28'd0, e_ram_en ? data_sram_wmask : 4'b0000});
        check32("ram_addr", ram_addr, data_sram_addr);
        check32("ram_wdata", ram_wdata, data_sram_wdata);
        check32("rdata", data_sram_rdata, m_pend_mmio ? m_pend_val : ram_rdata);
        check32("led", {16'h0, led}, {16'h0, m_led});
        check32("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
    endtask

    task automatic tick();
        #1 compare_now();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic wen, input logic [31:0] addr,
                         input logic [3:0] m, input logic [31:0] wd);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wmask = m;
        data_sram_wdata = wd;
        ram_rdata       = $urandom;
    endtask

    task automatic acc(input logic wen, input logic [31:0] addr, input logic [3:0] m, input logic [31:0] wd);
        drive(1'b1, wen, addr, m, wd);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        tick();
    endtask

    localparam logic [31:0] A_LED = 32'hBFAF_0000, A_SW = 32'hBFAF_0004, A_TMR = 32'hBFAF_0008,
                            A_CMP = 32'hBFAF_000C, A_IRQ = 32'hBFAF_0010, A_SCR = 32'hBFAF_0014;

    initial begin
        int n;
        int rst_hold;
        logic [31:0] a, wd;
        logic [15:0] offs [9];
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018, 16'h0040, 16'hFFFC};

        resetn = 1'b1;
        switch = 16'h1234;
        drive(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        #1 resetn = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) idle();
        check32("reset led", {16'h0, led}, 32'd0);
        check32("reset irq", {31'd0, timer_irq}, 32'd0);
        resetn = 1'b1;

        acc(1'b0, A_TMR, 4'h0, 32'd0);
        check32("timer after release", data_sram_rdata, 32'd0);
        acc(1'b0, A_CMP, 4'h0, 32'd0);
        check32("cmp reset value", data_sram_rdata, 32'hFFFF_FFFF);

        acc(1'b1, A_LED, 4'b0001, 32'hAAAA_5555);
        check32("led byte0", {16'h0, led}, 32'h0000_0055);
        acc(1'b1, A_LED, 4'b0010, 32'hAAAA_5555);
        check32("led byte1", {16'h0, led}, 32'h0000_5555);
        acc(1'b0, A_LED, 4'h0, 32'd0);
        check32("led readback", data_sram_rdata, 32'h0000_5555);

        drive(1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'h1234_5678);
        #1;
        check32("ram pass en", {31'd0, ram_en}, 32'd1);
        check32("ram pass wmask", {28'd0, ram_wmask}, 32'h3);
        tick();
        acc(1'b0, 32'h0000_0100, 4'h0, 32'd0);
        check32("ram read return", data_sram_rdata, ram_rdata);
        check32("led untouched", {16'h0, led}, 32'h0000_5555);

        acc(1'b1, A_CMP, 4'hF, 32'd20);
        acc(1'b1, A_TMR, 4'hF, 32'd0);
        n = 0;
        while (!timer_irq && n < 100) begin
            idle();
            n++;
        end
        check32("irq rise delay", n, 32'd21);
        acc(1'b1, A_IRQ, 4'b0001, 32'd1);
        check32("irq cleared", {31'd0, timer_irq}, 32'd0);
        acc(1'b1, A_CMP, 4'hF, 32'd10);
        acc(1'b1, A_TMR, 4'hF, 32'd10);
        acc(1'b1, A_IRQ, 4'b0001, 32'd1);
        check32("irq set beats clear", {31'd0, timer_irq}, 32'd1);
        acc(1'b1, A_IRQ, 4'b0001, 32'd1);
        check32("irq clear after", {31'd0, timer_irq}, 32'd0);

        switch = 16'hBEEF;
        acc(1'b0, A_SW, 4'h0, 32'd0);
        check32("switch sync 0", data_sram_rdata, 32'h0000_1234);
        acc(1'b0, A_SW, 4'h0, 32'd0);
        check32("switch sync 1", data_sram_rdata, 32'h0000_1234);
        acc(1'b0, A_SW, 4'h0, 32'd0);
        check32("switch sync 2", data_sram_rdata, 32'h0000_BEEF);

        acc(1'b1, A_SCR, 4'hF, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'd0);
        tick();
        drive(1'b1, 1'b0, A_SCR, 4'h0, 32'd0);
        #1 check32("ilv ram0", data_sram_rdata, ram_rdata);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0204, 4'h0, 32'd0);
        #1 check32("ilv scratch", data_sram_rdata, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'hBFAF_0040, 4'h0, 32'd0);
        #1 check32("ilv ram1", data_sram_rdata, ram_rdata);
        tick();
        drive(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        #1 check32("unmapped read", data_sram_rdata, 32'd0);
        tick();

        acc(1'b0, A_SCR, 4'h0, 32'd0);
        resetn = 1'b0;
        model_reset();
        #1;
        check32("reset drops pending", data_sram_rdata, ram_rdata);
        check32("reset led mid", {16'h0, led}, 32'd0);
        idle();
        idle();
        resetn = 1'b1;

        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!resetn) begin
                rst_hold--;
                if (rst_hold <= 0) resetn = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                #2 resetn = 1'b0;
                model_reset();
                rst_hold = 2;
            end
            if ($urandom_range(0, 15) == 0) switch = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a = {16'hBFAF, offs[$urandom_range(0, 8)]};
            end else begin
                a = $urandom & 32'hFFFF_FFFC;
                if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
            end
            wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                  4'($urandom_range(0, 15)), wd);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
